// File: rtl/keccak_pkg.sv
// -----------------------------------------------------------------------------
// keccak_pkg
// Shared constants and types for the Keccak front-end and the permutation
// neighbours: lane geometry, the final pad bit, the pad/pack state encoding
// and the (x,y) -> lane index mapping.
// -----------------------------------------------------------------------------
package keccak_pkg;

    localparam int         NUM_LANES = 25;
    localparam int         LANE_W    = 64;
    localparam logic [7:0] PAD_END   = 8'h80;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PAD,
        ZERO,
        ZERO_CAP
    } state_e;

    // Lane index within the 5x5 state, x running fastest.
    function automatic logic [4:0] lane_index(input logic [2:0] x, input logic [2:0] y);
        logic [4:0] idx;
        idx = 5'(5 * int'(y) + int'(x));
        return idx;
    endfunction

endpackage

// File: rtl/keccak_pad_pack_lane_obuf.sv
// -----------------------------------------------------------------------------
// lane_obuf
// One-entry registered output stage with valid/stop handshake. A new lane is
// captured whenever the entry is empty or being drained in the same cycle;
// while pushout_o && stopout_i the held lane and its flags stay frozen.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   load_i        offer a lane this cycle
//   data_i        lane payload
//   first_i       lane-0-of-block flag travelling with the lane
//   last_i        final-lane-of-message flag travelling with the lane
//   stopout_i     downstream back-pressure
//   can_load_o    an offered lane is taken this cycle
//   pushout_o     entry valid
//   dout_o        held lane
//   firstout_o    held first flag
//   lastout_o     held last flag
// -----------------------------------------------------------------------------
module lane_obuf
    import keccak_pkg::*;
#(
    parameter int W = LANE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         first_i,
    input  logic         last_i,
    input  logic         stopout_i,
    output logic         can_load_o,
    output logic         pushout_o,
    output logic [W-1:0] dout_o,
    output logic         firstout_o,
    output logic         lastout_o
);

    logic         vld_q;
    logic [W-1:0] data_q;
    logic         first_q;
    logic         last_q;

    // Empty, or the current occupant leaves at this edge.
    assign can_load_o = !vld_q || !stopout_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= 1'b0;
            data_q  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (load_i && can_load_o) begin
            vld_q   <= 1'b1;
            data_q  <= data_i;
            first_q <= first_i;
            last_q  <= last_i;
        end else if (!stopout_i) begin
            vld_q   <= 1'b0;
        end
    end

    assign pushout_o  = vld_q;
    assign dout_o     = data_q;
    assign firstout_o = first_q;
    assign lastout_o  = last_q;

endmodule

// File: rtl/keccak_pad_pack.sv
// -----------------------------------------------------------------------------
// keccak_pad_pack
// Byte-serial SHA-3 front end. Packs message bytes little-endian into 64-bit
// lanes, applies domain padding (PAD_BYTE ... 0x80) at a rate of RATE_LANES
// lanes, and emits every block as 25 lanes in x-fastest order with zero
// capacity lanes.
//
// Ports
//   clk, rst   clock, asynchronous active-high reset
//   pushin     input byte valid
//   stopin     back-pressure to upstream (combinational)
//   firstin    first byte of a message (qualified by pushin)
//   lastin     last byte of a message (qualified by pushin)
//   din        message byte
//   pushout    lane valid
//   stopout    downstream back-pressure
//   firstout   lane 0 of every block
//   lastout    lane 24 of the final block of a message
//   dout       lane data
// -----------------------------------------------------------------------------
module keccak_pad_pack
    import keccak_pkg::*;
#(
    parameter int         RATE_LANES = 17,
    parameter logic [7:0] PAD_BYTE   = 8'h06
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pushin,
    output logic              stopin,
    input  logic              firstin,
    input  logic              lastin,
    input  logic [7:0]        din,
    output logic              pushout,
    input  logic              stopout,
    output logic              firstout,
    output logic              lastout,
    output logic [LANE_W-1:0] dout
);

    localparam logic [4:0] RATE_LAST = 5'(RATE_LANES - 1);
    localparam logic [4:0] LAST_LANE = lane_index(3'd4, 3'd4);

    state_e            state_q, state_d;
    logic [2:0]        bc_q, bc_d;
    logic [4:0]        lc_q, lc_d;
    logic [LANE_W-1:0] acc_q, acc_d;
    // Message ended exactly on a rate boundary: after this block's capacity
    // lanes, a whole padding-only block still has to follow.
    logic              pend_q, pend_d;

    logic              busy;
    logic              accept;
    logic              can_load;
    logic              ld;
    logic [LANE_W-1:0] ld_data;
    logic              ld_first;
    logic              ld_last;
    logic [LANE_W-1:0] byte_lane;
    logic [LANE_W-1:0] pad_lane;

    assign busy   = (state_q == PAD) || (state_q == ZERO) || (state_q == ZERO_CAP);
    // In DATA this also guarantees the buffer can take a lane completed by
    // the accepted byte.
    assign stopin = busy || (pushout && stopout);
    assign accept = pushin && !stopin;

    // Accumulator with the incoming byte merged at position bc.
    always_comb begin
        byte_lane = acc_q;
        byte_lane[{bc_q, 3'b000} +: 8] = din;
    end

    // Partial lane closed with the domain byte; bytes above bc are already
    // zero in the accumulator. On the last rate lane the end bit lands in
    // byte 7, merging with the domain byte when both share that byte.
    always_comb begin
        pad_lane = acc_q | (LANE_W'(PAD_BYTE) << {bc_q, 3'b000});
        if (lc_q == RATE_LAST) begin
            pad_lane[LANE_W-1 -: 8] = pad_lane[LANE_W-1 -: 8] | PAD_END;
        end
    end

    always_comb begin
        state_d  = state_q;
        bc_d     = bc_q;
        lc_d     = lc_q;
        acc_d    = acc_q;
        pend_d   = pend_q;
        ld       = 1'b0;
        ld_data  = '0;
        ld_first = (lc_q == 5'd0);
        ld_last  = 1'b0;

        case (state_q)
            IDLE: begin
                // Bytes outside a message are discarded.
                if (accept && firstin) begin
                    acc_d   = {{(LANE_W-8){1'b0}}, din};
                    bc_d    = 3'd1;
                    lc_d    = 5'd0;
                    pend_d  = 1'b0;
                    state_d = lastin ? PAD : DATA;
                end
            end

            DATA: begin
                if (accept) begin
                    if (bc_q == 3'd7) begin
                        ld      = 1'b1;
                        ld_data = byte_lane;
                        acc_d   = '0;
                        bc_d    = 3'd0;
                        lc_d    = lc_q + 5'd1;
                        if (lc_q == RATE_LAST) begin
                            state_d = ZERO_CAP;
                            pend_d  = lastin;
                        end else if (lastin) begin
                            state_d = PAD;
                        end
                    end else begin
                        acc_d = byte_lane;
                        bc_d  = bc_q + 3'd1;
                        if (lastin) begin
                            state_d = PAD;
                        end
                    end
                end
            end

            PAD: begin
                ld      = 1'b1;
                ld_data = pad_lane;
                if (can_load) begin
                    acc_d   = '0;
                    bc_d    = 3'd0;
                    lc_d    = lc_q + 5'd1;
                    state_d = ZERO;
                end
            end

            ZERO: begin
                ld      = 1'b1;
                ld_data = (lc_q == RATE_LAST) ? {PAD_END, {(LANE_W-8){1'b0}}} : '0;
                ld_last = (lc_q == LAST_LANE);
                if (can_load) begin
                    if (lc_q == LAST_LANE) begin
                        lc_d    = 5'd0;
                        state_d = IDLE;
                    end else begin
                        lc_d = lc_q + 5'd1;
                    end
                end
            end

            ZERO_CAP: begin
                ld      = 1'b1;
                ld_data = '0;
                if (can_load) begin
                    if (lc_q == LAST_LANE) begin
                        lc_d    = 5'd0;
                        pend_d  = 1'b0;
                        // PAD then starts a fresh block at lane 0, byte 0.
                        state_d = pend_q ? PAD : DATA;
                    end else begin
                        lc_d = lc_q + 5'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bc_q    <= 3'd0;
            lc_q    <= 5'd0;
            acc_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bc_q    <= bc_d;
            lc_q    <= lc_d;
            acc_q   <= acc_d;
            pend_q  <= pend_d;
        end
    end

    lane_obuf #(
        .W (LANE_W)
    ) u_obuf (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ld),
        .data_i     (ld_data),
        .first_i    (ld_first),
        .last_i     (ld_last),
        .stopout_i  (stopout),
        .can_load_o (can_load),
        .pushout_o  (pushout),
        .dout_o     (dout),
        .firstout_o (firstout),
        .lastout_o  (lastout)
    );

endmodule

// File: tb/tb_keccak_pad_pack.sv
`timescale 1ns/1ps
module tb_keccak_pad_pack;
    import keccak_pkg::*;

    localparam int R = 17;

    logic        clk = 1'b0;
    logic        rst;
    logic        pushin, stopin, firstin, lastin;
    logic [7:0]  din;
    logic        pushout, stopout, firstout, lastout;
    logic [63:0] dout;

    always #5 clk = ~clk;

    keccak_pad_pack #(.RATE_LANES(R), .PAD_BYTE(8'h06)) dut (
        .clk(clk), .rst(rst), .pushin(pushin), .stopin(stopin),
        .firstin(firstin), .lastin(lastin), .din(din),
        .pushout(pushout), .stopout(stopout), .firstout(firstout),
        .lastout(lastout), .dout(dout)
    );

    typedef struct packed {
        logic [63:0] d;
        logic        f;
        logic        l;
    } lane_t;

    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    int     stall_cnt = 0;
    bit     stall_rand = 0;
    int     stall_from = 0;
    int     stall_to = 0;
    lane_t  outq[$];
    lane_t  expq[$];
    logic [7:0] msg[$];
    logic [7:0] junk[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Output monitor: collects accepted lanes and watches the hold behaviour.
    lane_t prev;
    bit    prev_stalled = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stalled = 0;
        end else begin
            if (prev_stalled)
                chk("hold", {pushout, dout, firstout, lastout}, {1'b1, prev});
            if (pushout && stopout) begin
                chk("stopin_full", stopin, 1);
                stall_cnt++;
            end
            prev_stalled = pushout && stopout;
            prev = {dout, firstout, lastout};
            if (pushout && !stopout) outq.push_back({dout, firstout, lastout});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (stall_rand) stopout = ($urandom_range(0, 3) == 0);
        else            stopout = (cyc >= stall_from && cyc < stall_to);
    endtask

    // Reference: SHA-3 pad10*1 with domain byte, split into blocks of R lanes
    // followed by zero capacity lanes.
    function automatic void build_exp(input logic [7:0] m[$]);
        logic [7:0] p[$];
        int nb;
        p = m;
        p.push_back(8'h06);
        while (p.size() % (R * 8) != 0) p.push_back(8'h00);
        p[p.size() - 1] = p[p.size() - 1] | 8'h80;
        nb = p.size() / (R * 8);
        expq.delete();
        for (int b = 0; b < nb; b++) begin
            for (int y = 0; y < 5; y++) begin
                for (int x = 0; x < 5; x++) begin
                    int L;
                    logic [63:0] w;
                    L = int'(lane_index(3'(x), 3'(y)));
                    w = '0;
                    if (L < R)
                        for (int k = 0; k < 8; k++) w[8*k +: 8] = p[(b * R + L) * 8 + k];
                    expq.push_back({w, (L == 0), (b == nb - 1) && (L == 24)});
                end
            end
        end
    endfunction

    task automatic send(input logic [7:0] m[$], input bit mark_first, input bit mark_last,
                        input bit chk_lat, output int first_wait);
        bit lat_pend;
        int lat_idx;
        int wait_c;
        int j;
        lat_pend = 0;
        lat_idx = 0;
        first_wait = 0;
        for (int i = 0; i < m.size(); i++) begin
            pushin  = 1'b1;
            din     = m[i];
            firstin = mark_first && (i == 0);
            lastin  = mark_last && (i == m.size() - 1);
            wait_c  = 0;
            @(negedge clk);
            if (lat_pend) begin
                chk("latency", {pushout, dout}, {1'b1, expq[lat_idx].d});
                lat_pend = 0;
            end
            while (stopin) begin
                tick();
                wait_c++;
                if (wait_c > 2000) begin
                    failures++;
                    $display("FAIL send_timeout observed=stuck required=byte_accept");
                    $fatal(1, "input stalled indefinitely");
                end
                @(negedge clk);
            end
            if (i == 0) first_wait = wait_c;
            tick();
            if (chk_lat && (i % 8 == 7)) begin
                j = i / 8;
                lat_idx = (j / R) * 25 + (j % R);
                lat_pend = 1;
            end
        end
        pushin = 1'b0; firstin = 1'b0; lastin = 1'b0;
        if (lat_pend) begin
            @(negedge clk);
            chk("latency", {pushout, dout}, {1'b1, expq[lat_idx].d});
        end
    endtask

    task automatic wait_lanes(input int n);
        int b;
        b = 0;
        while (outq.size() < n && b < 3000) begin
            tick();
            b++;
        end
        chk("lane_count", outq.size(), n);
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < expq.size() && i < outq.size(); i++)
            chk($sformatf("%s_lane%0d", tag, i), outq[i], expq[i]);
    endtask

    task automatic run_abc(input string tag);
        int fw;
        msg = '{8'h61, 8'h62, 8'h63};
        outq.delete();
        build_exp(msg);
        send(msg, 1, 1, 0, fw);
        wait_lanes(25);
        compare_all(tag);
        chk({tag, "_lane0"},  outq[0],  {64'h0000_0000_0663_6261, 1'b1, 1'b0});
        chk({tag, "_lane16"}, outq[16], {64'h8000_0000_0000_0000, 1'b0, 1'b0});
        chk({tag, "_lane24"}, outq[24], {64'h0, 1'b0, 1'b1});
    endtask

    int fw;
    int s0;
    int lens[10] = '{1, 7, 8, 9, 135, 136, 137, 271, 272, 0};

    initial begin
        rst = 1'b1; pushin = 1'b0; firstin = 1'b0; lastin = 1'b0; din = 8'h00; stopout = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {stopin, pushout, firstout, lastout, dout}, 68'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Bytes without firstin while idle are dropped, then "abc".
        junk = '{8'h11, 8'h22, 8'h33};
        send(junk, 0, 1, 0, fw);
        repeat (3) tick();
        chk("dropped_no_output", outq.size(), 0);
        run_abc("abc");

        // 135 bytes of 0xAA: pad byte and end bit share byte 7 of lane 16.
        msg.delete();
        for (int i = 0; i < 135; i++) msg.push_back(8'hAA);
        outq.delete();
        build_exp(msg);
        send(msg, 1, 1, 1, fw);
        wait_lanes(25);
        compare_all("aa135");
        chk("aa135_lane16", outq[16], {64'h86AA_AAAA_AAAA_AAAA, 1'b0, 1'b0});
        chk("aa135_lane3",  outq[3],  {64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b0});

        // 136 zero bytes: rate exactly full, a second padding-only block.
        msg.delete();
        for (int i = 0; i < 136; i++) msg.push_back(8'h00);
        outq.delete();
        build_exp(msg);
        send(msg, 1, 1, 1, fw);
        wait_lanes(50);
        compare_all("z136");
        chk("z136_lane0",  outq[0],  {64'h0, 1'b1, 1'b0});
        chk("z136_lane24", outq[24], {64'h0, 1'b0, 1'b0});
        chk("z136_lane25", outq[25], {64'h06, 1'b1, 1'b0});
        chk("z136_lane41", outq[41], {64'h8000_0000_0000_0000, 1'b0, 1'b0});
        chk("z136_lane49", outq[49], {64'h0, 1'b0, 1'b1});

        // Ten-cycle downstream stall in the middle of a block.
        msg.delete();
        for (int i = 0; i < 64; i++) msg.push_back(8'($urandom));
        outq.delete();
        build_exp(msg);
        s0 = stall_cnt;
        stall_from = cyc + 20;
        stall_to   = cyc + 30;
        send(msg, 1, 1, 0, fw);
        wait_lanes(25);
        compare_all("stall");
        chk("stall_seen", (stall_cnt > s0), 1);
        stall_from = 0; stall_to = 0;

        // Reset in the middle of a message, then "abc" again.
        msg.delete();
        for (int i = 0; i < 20; i++) msg.push_back(8'($urandom));
        send(msg, 1, 0, 0, fw);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_outs", {stopin, pushout, firstout, lastout, dout}, 68'h0);
            tick();
        end
        rst = 1'b0;
        run_abc("post_rst");

        // Single byte message, then a message back to back.
        msg = '{8'hFF};
        outq.delete();
        build_exp(msg);
        send(msg, 1, 1, 0, fw);
        wait_lanes(25);
        compare_all("ff");
        chk("ff_lane0", outq[0], {64'h06FF, 1'b1, 1'b0});
        msg.delete();
        for (int i = 0; i < 40; i++) msg.push_back(8'($urandom));
        outq.delete();
        build_exp(msg);
        send(msg, 1, 1, 0, fw);
        chk("b2b_first_wait", fw, 0);
        wait_lanes(25);
        compare_all("b2b");

        // Randomized messages with random back-pressure and stray bytes.
        stall_rand = 1;
        for (int t = 0; t < 10; t++) begin
            int n;
            n = (lens[t] == 0) ? int'($urandom_range(1, 400)) : lens[t];
            junk.delete();
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) junk.push_back(8'($urandom));
            msg.delete();
            for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
            outq.delete();
            build_exp(msg);
            if (junk.size() > 0) send(junk, 0, 0, 0, fw);
            send(msg, 1, 1, 0, fw);
            wait_lanes(expq.size());
            compare_all($sformatf("rnd%0d", t));
            repeat (4) tick();
            chk($sformatf("rnd%0d_no_extra", t), outq.size(), expq.size());
        end
        stall_rand = 0;
        stopout = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keccak_pad_pack.md
# keccak_pad_pack

Upstream neighbour of `perm_blk`. Accepts a byte-serial message, applies SHA-3 domain padding (0x06 … 0x80) at rate RATE_LANES×8 bytes, and packs bytes little-endian into 64-bit lanes. Emits each block as 25 lanes in x-fastest order (x=0..4 inside y=0..4), matching the permutation's input order. Capacity lanes are zero.

## Interface
- RATE_LANES, 17, rate in 64-bit lanes (1..24); SHA3-256 default.
- PAD_BYTE, 8'h06, domain-separation byte.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pushin  in  1  input byte valid.
- stopin  out  1  back-pressure to upstream.
- firstin  in  1  first byte of a message, qualified by pushin.
- lastin  in  1  last byte of a message, qualified by pushin; may coincide with firstin.
- din  in  8  message byte.
- pushout  out  1  lane valid.
- stopout  in  1  downstream back-pressure.
- firstout  out  1  marks lane 0 of every block.
- lastout  out  1  marks lane 24 of the final block of a message.
- dout  out  64  lane data.

## Operation
- Byte accepted when pushin && !stopin. Lane accepted when pushout && !stopout.
- Byte k (0..7) of a lane occupies dout[8k+7:8k]. Lane index L = 5y+x, with 0..RATE_LANES-1 as rate and RATE_LANES..24 as capacity.
- State IDLE: stopin=0.
  - An accepted byte with firstin loads byte 0, then goes to DATA.
  - An accepted byte without firstin is dropped.
  - A byte with firstin and lastin goes straight to PAD.
- State DATA:
  - Accepted bytes fill the accumulator at byte count bc (0..7).
  - On bc=7 the lane is handed to the output buffer, bc wraps to 0, and lane count lc increments.
  - firstin is ignored in DATA.
  - The accepted byte with lastin goes to PAD.
  - If lc reaches RATE_LANES with no lastin, go to ZERO_CAP, then back to DATA with lc=0 for the next block.
- State PAD: takes one cycle and emits one lane.
  - The current partial lane gets PAD_BYTE at byte position bc; higher bytes are zero.
  - If bc=0 after a wrap, PAD_BYTE goes to byte 0 of a fresh lane.
  - If lc=RATE_LANES (rate exactly full), a new block starts: lane 0 = PAD_BYTE, and the 0x80 bit applies at lane RATE_LANES-1.
  - The lane at lc=RATE_LANES-1 gets byte 7 |= 8'h80. When byte 7 also holds the pad byte, it becomes 8'h86.
  - Then go to ZERO.
- State ZERO: emits the remaining rate lanes (zero, except lane RATE_LANES-1 = 64'h80<<56 when not yet emitted) and the capacity lanes, one lane per cycle when unstalled.
  - lastout is set on lane 24. After lane 24 is accepted, return to IDLE.
- State ZERO_CAP: emits capacity lanes for a non-final block. lastout=0.
- stopin is combinational: 1 in PAD/ZERO/ZERO_CAP, or when the output buffer is full && stopout; otherwise 0.
- Reset, including mid-message: state IDLE; bc, lc and accumulator cleared; output buffer emptied; partial block discarded. The next message starts at lane 0 with firstout.

## Timing
- Reset values: stopin=0, pushout=0, firstout=0, lastout=0, dout=0.
- Latency: a lane appears on pushout the cycle after its 8th byte is accepted.
- Throughput: 1 byte/cycle in; pad and zero lanes at 1 lane/cycle.
- Back-pressure: dout, firstout and lastout are held stable while pushout && stopout. The output buffer is a single entry.
  - A lane completes only when the buffer is empty or draining that cycle; stopin guarantees this.
- Back-to-back messages: firstin is accepted in the cycle after lane 24 of the previous message is accepted.
- Lane count wraps 24→0. Byte count wraps 7→0.

## Structure
- Package keccak_pkg holds:
  - NUM_LANES=25 and LANE_W=64.
  - PAD_END=8'h80.
  - State enum {IDLE, DATA, PAD, ZERO, ZERO_CAP}.
  - A lane index function, index(x,y)=5y+x.
- Sub-module lane_obuf: the one-entry output register with the pushout/stopout hold logic. It is shared with the downstream squeeze stage.

## Test plan
- "abc" (61,62,63; lastin on 63), stopout=0 → 25 lanes:
  - lane0=64'h0000_0000_0663_6261 with firstout.
  - lanes 1–15 = 0; lane16=64'h8000_0000_0000_0000; lanes 17–24 = 0.
  - lastout only on lane 24.
- 135 bytes of 0xAA → lane16=64'h86AA_AAAA_AAAA_AAAA. All other rate lanes are all-AA.
- 136 bytes of 0x00 → 50 lanes. firstout on lanes 0 and 25. Block 2: lane0=64'h06, lane16=64'h80<<56. lastout only on lane 49.
- stopout high for 10 cycles mid-block → dout stable, stopin=1 once the buffer is full, no byte lost or reordered.
- rst pulsed after 20 bytes, then "abc" → output identical to scenario 1. All outputs are 0 while rst is high.
- Single byte with firstin=lastin=1 (0xFF) → lane0=64'h06FF. Then a new message is accepted the cycle after lane 24 is accepted.
